// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and opcode names for the ALU arbiter and its benches.
// The arbiter itself never decodes opcodes; the names exist for stimulus readability.
package alu_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OPC_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } arb_state_t;

  localparam logic [OPC_W-1:0] OPC_ADDC    = 3'd0;
  localparam logic [OPC_W-1:0] OPC_ADDHALF = 3'd1;
  localparam logic [OPC_W-1:0] OPC_MAX     = 3'd2;
  localparam logic [OPC_W-1:0] OPC_TRIPLE  = 3'd3;
  localparam logic [OPC_W-1:0] OPC_AND     = 3'd4;
  localparam logic [OPC_W-1:0] OPC_OR      = 3'd5;
  localparam logic [OPC_W-1:0] OPC_NOT     = 3'd6;
  localparam logic [OPC_W-1:0] OPC_ZERO    = 3'd7;

  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_id,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_id ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: the winning operation is
// registered into the ALU inputs, its result captured after one cycle and handed back.
module alu_arbiter #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned OPC_W = alu_pkg::OPC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  // Request side
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [OPC_W-1:0]        req_opc0,
  input  logic [OPC_W-1:0]        req_opc1,
  input  logic signed [WIDTH-1:0] req_m0,
  input  logic signed [WIDTH-1:0] req_m1,
  input  logic signed [WIDTH-1:0] req_n0,
  input  logic signed [WIDTH-1:0] req_n1,
  input  logic [1:0]              req_c,
  // Response side
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [WIDTH-1:0]        rsp_f,
  output logic                    rsp_neg,
  output logic                    rsp_zer,
  output logic                    rsp_id,
  // External ALU
  output logic signed [WIDTH-1:0] alu_m,
  output logic signed [WIDTH-1:0] alu_n,
  output logic                    alu_c,
  output logic [OPC_W-1:0]        alu_opc,
  input  logic [WIDTH-1:0]        alu_f,
  input  logic                    alu_neg,
  input  logic                    alu_zer,
  output logic                    busy
);

  import alu_pkg::*;

  arb_state_t state_q, state_d;
  logic       owner_q;
  logic       last_q;
  logic [1:0] grant;
  logic       grant_id;
  logic       accept;

  rr_arb2 u_rr_arb2 (
    .req     (req_valid),
    .last_id (last_q),
    .grant   (grant)
  );

  assign grant_id = grant[1];

  // Gated by rst so no handshake can appear while the block is being reset.
  assign req_ready = (state_q == StIdle && !rst) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  assign rsp_valid = (state_q == StResp) ? id_to_onehot(owner_q) : 2'b00;
  assign rsp_id    = owner_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready[owner_q]) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != StIdle);
      if (accept) begin
        owner_q <= grant_id;
        last_q  <= grant_id;
      end
    end
  end

  // ALU operand registers keep their last value until the next accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_m   <= '0;
      alu_n   <= '0;
      alu_c   <= 1'b0;
      alu_opc <= '0;
    end else if (accept) begin
      alu_m   <= grant_id ? req_m1   : req_m0;
      alu_n   <= grant_id ? req_n1   : req_n0;
      alu_opc <= grant_id ? req_opc1 : req_opc0;
      alu_c   <= req_c[grant_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_f   <= '0;
      rsp_neg <= 1'b0;
      rsp_zer <= 1'b0;
    end else if (state_q == StExec) begin
      rsp_f   <= alu_f;
      rsp_neg <= alu_neg;
      rsp_zer <= alu_zer;
    end
  end

endmodule
